// File: rtl/param_shift_unit_if.sv
// param_shift_unit_if: load/shift handshake bundle between a controller and param_shift_unit
// Parameters: WIDTH data width, SHAMT_W shift-amount width
// master (controller): drives load, in, start, mode, shamt, ser_in; reads out, ser_out, busy, done
// slave (shift unit): the reverse. zero exists only with SHIFTREG_ZERO_FLAG_EN defined
interface param_shift_unit_if #(parameter int WIDTH = 6, parameter int SHAMT_W = 3);
    logic               load;
    logic [WIDTH-1:0]   in;
    logic               start;
    logic [1:0]         mode;
    logic [SHAMT_W-1:0] shamt;
    logic               ser_in;
    logic [WIDTH-1:0]   out;
    logic               ser_out;
    logic               busy;
    logic               done;
`ifdef SHIFTREG_ZERO_FLAG_EN
    logic               zero;
    modport master(output load, in, start, mode, shamt, ser_in, input out, ser_out, busy, done, zero);
    modport slave(input load, in, start, mode, shamt, ser_in, output out, ser_out, busy, done, zero);
`else
    modport master(output load, in, start, mode, shamt, ser_in, input out, ser_out, busy, done);
    modport slave(input load, in, start, mode, shamt, ser_in, output out, ser_out, busy, done);
`endif
endinterface

// File: rtl/param_shift_unit.sv
// param_shift_unit: loadable WIDTH-bit register with multi-cycle programmable shift (one bit per clock)
// Ports: clk, rst (sync, active-high), s (param_shift_unit_if.slave)
//   load/in parallel load (aborts any shift), start/mode/shamt begin a shift from IDLE,
//   ser_in fill bit, out register, ser_out last bit shifted out, busy while steps remain,
//   done one-cycle completion pulse
// Modes: 00 logical right, 01 arithmetic right, 10 logical left, 11 rotate right
// Optional: SHIFTREG_ZERO_FLAG_EN adds registered s.zero = (out == 0), reset value 1
module param_shift_unit #(
    parameter int WIDTH   = 6,
    parameter int SHAMT_W = 3
) (
    input logic            clk,
    input logic            rst,
    param_shift_unit_if.slave s
);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t             state;
    logic [SHAMT_W-1:0] cnt;
    logic [1:0]         mode_q;
    logic [WIDTH-1:0]   out_q;
    logic [WIDTH-1:0]   nxt;
    logic               ser_q;
    logic               so;
    logic               busy_q;
    logic               done_q;
    always_comb begin
        nxt = mode_q == 2'b00 ? {s.ser_in, out_q[WIDTH-1:1]} :
              mode_q == 2'b01 ? {out_q[WIDTH-1], out_q[WIDTH-1:1]} :
              mode_q == 2'b10 ? {out_q[WIDTH-2:0], s.ser_in} :
                                {out_q[0], out_q[WIDTH-1:1]};
        so  = mode_q == 2'b10 ? out_q[WIDTH-1] : out_q[0];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            mode_q <= 2'b00;
            out_q  <= '0;
            ser_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (s.load) begin
            state  <= IDLE;
            cnt    <= '0;
            out_q  <= s.in;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (state == IDLE) begin
            done_q <= s.start && s.shamt == '0;
            if (s.start) begin
                mode_q <= s.mode;
                if (s.shamt != '0) begin
                    cnt    <= s.shamt;
                    busy_q <= 1'b1;
                    state  <= SHIFT;
                end
            end
        end else begin
            out_q <= nxt;
            ser_q <= so;
            cnt   <= cnt - 1'b1;
            if (cnt == 1) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
                state  <= IDLE;
            end
        end
    end
`ifdef SHIFTREG_ZERO_FLAG_EN
    logic zero_q;
    always_ff @(posedge clk) begin
        if (rst)
            zero_q <= 1'b1;
        else if (s.load)
            zero_q <= s.in == '0;
        else if (state == SHIFT)
            zero_q <= nxt == '0;
    end
    assign s.zero = zero_q;
`endif
    assign s.out     = out_q;
    assign s.ser_out = ser_q;
    assign s.busy    = busy_q;
    assign s.done    = done_q;
endmodule
